// File: rtl/m_rect_fill_pkg.sv
// Shared definitions for the rectangle fill engine: screen defaults, FSM
// encodings, pixel format width and the border-membership helper.
package m_rect_fill_pkg;

   localparam int SCREEN_W_DEF = 240;
   localparam int SCREEN_H_DEF = 240;
   localparam int RGB565_W     = 16;
   localparam int COORD_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLIP = 2'd1,
      ST_DRAW = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0]  x0;
      logic [COORD_W-1:0]  y0;
      logic [COORD_W-1:0]  w;
      logic [COORD_W-1:0]  h;
      logic [RGB565_W-1:0] color;
      logic                outline;
   } cmd_t;

   // True when (x,y) lies on the clipped rectangle's 1-pixel border.
   function automatic logic on_border(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input logic [COORD_W-1:0] x0,
      input logic [COORD_W-1:0] y0,
      input logic [COORD_W-1:0] xe,
      input logic [COORD_W-1:0] ye
   );
      return (x == x0) || (x == xe) || (y == y0) || (y == ye);
   endfunction

endpackage

// File: rtl/m_rect_clip.sv
// Combinational clip/reject stage: clamps the rectangle's far corner to the
// screen and flags commands that would draw nothing.
module m_rect_clip
   import m_rect_fill_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   output logic [COORD_W-1:0] xe,
   output logic [COORD_W-1:0] ye,
   output logic               reject
);

   localparam logic [8:0] XLIM_C = 9'(SCREEN_W - 1);
   localparam logic [8:0] YLIM_C = 9'(SCREEN_H - 1);
   localparam logic [8:0] XMAX_C = 9'(SCREEN_W);
   localparam logic [8:0] YMAX_C = 9'(SCREEN_H);

   logic [8:0] xend_s;
   logic [8:0] yend_s;

   // 9-bit sums so a far corner up to 509 never wraps before clamping.
   always_comb begin
      xend_s = {1'b0, x0} + {1'b0, w} - 9'd1;
      yend_s = {1'b0, y0} + {1'b0, h} - 9'd1;
      if (xend_s > XLIM_C) begin
         xe = XLIM_C[7:0];
      end else begin
         xe = xend_s[7:0];
      end
      if (yend_s > YLIM_C) begin
         ye = YLIM_C[7:0];
      end else begin
         ye = yend_s[7:0];
      end
      reject = (w == 8'd0) || (h == 8'd0) ||
               ({1'b0, x0} >= XMAX_C) || ({1'b0, y0} >= YMAX_C);
   end

endmodule

// File: rtl/m_rect_fill.sv
// Rectangle fill/outline engine: accepts one command at a time and streams
// registered pixel writes in raster order straight into the vmem write port.
module m_rect_fill
   import m_rect_fill_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic                w_clk,
   input  logic                w_rst_n,
   input  logic                w_cmd_valid,
   output logic                w_cmd_ready,
   input  logic [COORD_W-1:0]  w_cmd_x0,
   input  logic [COORD_W-1:0]  w_cmd_y0,
   input  logic [COORD_W-1:0]  w_cmd_w,
   input  logic [COORD_W-1:0]  w_cmd_h,
   input  logic [RGB565_W-1:0] w_cmd_color,
   input  logic                w_cmd_outline,
   output logic [15:0]         w_st_wadr,
   output logic                w_st_we,
   output logic [RGB565_W-1:0] w_st_wdata,
   output logic                w_busy,
   output logic                w_done
);

   state_t               state_r;
   state_t               next_state_s;
   cmd_t                 cmd_r;
   logic [COORD_W-1:0]   x_r;
   logic [COORD_W-1:0]   y_r;
   logic [COORD_W-1:0]   x_nxt_s;
   logic [COORD_W-1:0]   y_nxt_s;
   logic [COORD_W-1:0]   xe_s;
   logic [COORD_W-1:0]   ye_s;
   logic                 reject_s;
   logic                 accept_s;

   logic                 ready_r;
   logic                 busy_r;
   logic                 we_r;
   logic                 done_r;
   logic [15:0]          wadr_r;
   logic [RGB565_W-1:0]  wdata_r;

   logic                 we_nxt_s;
   logic                 done_nxt_s;
   logic [15:0]          wadr_nxt_s;
   logic [RGB565_W-1:0]  wdata_nxt_s;

   // Ready is a register, so the handshake never loops back through inputs.
   assign accept_s = w_cmd_valid & ready_r;

   m_rect_clip #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_clip (
      .x0     (cmd_r.x0),
      .y0     (cmd_r.y0),
      .w      (cmd_r.w),
      .h      (cmd_r.h),
      .xe     (xe_s),
      .ye     (ye_s),
      .reject (reject_s)
   );

   // Command latch: only written on an accepted handshake, so traffic while busy is ignored.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         cmd_r <= '0;
      end else if (accept_s) begin
         cmd_r <= '{x0: w_cmd_x0, y0: w_cmd_y0, w: w_cmd_w, h: w_cmd_h,
                    color: w_cmd_color, outline: w_cmd_outline};
      end else begin
         cmd_r <= cmd_r;
      end
   end

   // Next-state, raster walk and the write about to be presented next cycle.
   always_comb begin
      next_state_s = state_r;
      x_nxt_s      = x_r;
      y_nxt_s      = y_r;
      done_nxt_s   = 1'b0;
      we_nxt_s     = 1'b0;
      wadr_nxt_s   = 16'd0;
      wdata_nxt_s  = 16'd0;

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_CLIP;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_CLIP: begin
            if (reject_s) begin
               next_state_s = ST_DONE;
               done_nxt_s   = 1'b1;
            end else begin
               next_state_s = ST_DRAW;
               x_nxt_s      = cmd_r.x0;
               y_nxt_s      = cmd_r.y0;
            end
         end
         ST_DRAW: begin
            if ((x_r == xe_s) && (y_r == ye_s)) begin
               next_state_s = ST_DONE;
               done_nxt_s   = 1'b1;
            end else if (x_r == xe_s) begin
               x_nxt_s = cmd_r.x0;
               y_nxt_s = y_r + 8'd1;
            end else begin
               x_nxt_s = x_r + 8'd1;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase

      // Outputs lead the walk by one register so the pixel is visible in its own DRAW cycle.
      if (next_state_s == ST_DRAW) begin
         wadr_nxt_s  = {y_nxt_s, x_nxt_s};
         wdata_nxt_s = cmd_r.color;
         we_nxt_s    = !cmd_r.outline ||
                       on_border(x_nxt_s, y_nxt_s, cmd_r.x0, cmd_r.y0, xe_s, ye_s);
      end else begin
         wadr_nxt_s  = 16'd0;
         wdata_nxt_s = 16'd0;
         we_nxt_s    = 1'b0;
      end
   end

   // State and raster position registers.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_r <= ST_IDLE;
         x_r     <= 8'd0;
         y_r     <= 8'd0;
      end else begin
         state_r <= next_state_s;
         x_r     <= x_nxt_s;
         y_r     <= y_nxt_s;
      end
   end

   // Registered outputs; reset clears them at once so a draw is cut off immediately.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         we_r    <= 1'b0;
         done_r  <= 1'b0;
         wadr_r  <= 16'd0;
         wdata_r <= 16'd0;
      end else begin
         ready_r <= (next_state_s == ST_IDLE);
         busy_r  <= (next_state_s != ST_IDLE);
         we_r    <= we_nxt_s;
         done_r  <= done_nxt_s;
         wadr_r  <= wadr_nxt_s;
         wdata_r <= wdata_nxt_s;
      end
   end

   assign w_cmd_ready = ready_r;
   assign w_busy      = busy_r;
   assign w_st_we     = we_r;
   assign w_done      = done_r;
   assign w_st_wadr   = wadr_r;
   assign w_st_wdata  = wdata_r;

endmodule

// File: tb/tb_m_rect_fill.sv
// Directed self-checking bench for m_rect_fill. Cycle 0 is the handshake
// cycle; cycle k is observed 1 time unit after the k-th following rising edge.
module tb_m_rect_fill;

   logic        w_clk = 1'b0;
   logic        w_rst_n;
   logic        w_cmd_valid;
   logic        w_cmd_ready;
   logic [7:0]  w_cmd_x0, w_cmd_y0, w_cmd_w, w_cmd_h;
   logic [15:0] w_cmd_color;
   logic        w_cmd_outline;
   logic [15:0] w_st_wadr;
   logic        w_st_we;
   logic [15:0] w_st_wdata;
   logic        w_busy;
   logic        w_done;

   int total = 0;
   int bad   = 0;

   logic [15:0] wr_adr_q[$];
   logic [15:0] wr_dat_q[$];
   int          wr_cyc_q[$];
   int          done_cyc_q[$];
   int          ready_at;
   logic        timed_out;

   m_rect_fill dut (
      .w_clk         (w_clk),
      .w_rst_n       (w_rst_n),
      .w_cmd_valid   (w_cmd_valid),
      .w_cmd_ready   (w_cmd_ready),
      .w_cmd_x0      (w_cmd_x0),
      .w_cmd_y0      (w_cmd_y0),
      .w_cmd_w       (w_cmd_w),
      .w_cmd_h       (w_cmd_h),
      .w_cmd_color   (w_cmd_color),
      .w_cmd_outline (w_cmd_outline),
      .w_st_wadr     (w_st_wadr),
      .w_st_we       (w_st_we),
      .w_st_wdata    (w_st_wdata),
      .w_busy        (w_busy),
      .w_done        (w_done)
   );

   always #5 w_clk = ~w_clk;

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge w_clk);
      #1;
   endtask

   // Records every write and done pulse until ready returns (bounded).
   task automatic collect(input int budget);
      wr_adr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
      ready_at  = -1;
      timed_out = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (w_st_we) begin
            wr_adr_q.push_back(w_st_wadr);
            wr_dat_q.push_back(w_st_wdata);
            wr_cyc_q.push_back(cyc);
         end
         if (w_done) done_cyc_q.push_back(cyc);
         if (w_cmd_ready) begin
            ready_at  = cyc;
            timed_out = 1'b0;
            break;
         end
         step();
      end
   endtask

   // Issues one command from a ready cycle, then collects its activity.
   task automatic issue(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                        input logic [7:0] h, input logic [15:0] c, input logic o);
      w_cmd_x0 = x0; w_cmd_y0 = y0; w_cmd_w = w; w_cmd_h = h;
      w_cmd_color = c; w_cmd_outline = o; w_cmd_valid = 1'b1;
      step();
      w_cmd_valid = 1'b0;
      collect(2000);
   endtask

   task automatic test_reset();
      w_rst_n = 1'b0; w_cmd_valid = 1'b0;
      w_cmd_x0 = 8'd0; w_cmd_y0 = 8'd0; w_cmd_w = 8'd0; w_cmd_h = 8'd0;
      w_cmd_color = 16'd0; w_cmd_outline = 1'b0;
      step(); step();
      total++;
      if ({w_st_we, w_done, w_busy, w_cmd_ready} !== 4'b0000 || w_st_wadr !== 16'd0 || w_st_wdata !== 16'd0) begin
         bad++;
         $display("FAIL reset_outputs: we/done/busy/ready=%b adr=%h data=%h, required 0000/0000/0000",
                  {w_st_we, w_done, w_busy, w_cmd_ready}, w_st_wadr, w_st_wdata);
      end
      w_rst_n = 1'b1;
      #1;
      total++;
      if (w_cmd_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready_before_edge: got %b required 0", w_cmd_ready);
      end
      step();
      total++;
      if (w_cmd_ready !== 1'b1 || w_busy !== 1'b0) begin
         bad++; $display("FAIL reset_ready_after_edge: ready=%b busy=%b required 1/0", w_cmd_ready, w_busy);
      end
   endtask

   task automatic test_fill();
      logic [15:0] exp_a [6];
      exp_a = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
      issue(8'd10, 8'd20, 8'd3, 8'd2, 16'hF800, 1'b0);
      total++;
      if (timed_out !== 1'b0 || wr_adr_q.size() !== 6) begin
         bad++; $display("FAIL fill_count: writes=%0d timeout=%b required 6/0", wr_adr_q.size(), timed_out);
      end
      for (int i = 0; i < wr_adr_q.size() && i < 6; i++) begin
         total++;
         if (wr_adr_q[i] !== exp_a[i] || wr_dat_q[i] !== 16'hF800) begin
            bad++; $display("FAIL fill_write%0d: adr=%h data=%h required %h/F800", i, wr_adr_q[i], wr_dat_q[i], exp_a[i]);
         end
      end
      total++;
      if (wr_cyc_q.size() < 1 || wr_cyc_q[0] !== 2 || wr_cyc_q[wr_cyc_q.size()-1] !== 7) begin
         bad++; $display("FAIL fill_write_window: first/last write cycle wrong, required 2..7");
      end
      // DONE follows the 6th DRAW cycle (2..7); IDLE is 3+6 cycles after the handshake.
      total++;
      if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 8 || ready_at !== 9) begin
         bad++; $display("FAIL fill_done: pulses=%0d ready_at=%0d required one pulse at 8, ready at 9",
                         done_cyc_q.size(), ready_at);
      end
   endtask

   task automatic test_outline();
      logic [15:0] exp_a [12];
      int interior;
      exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0100, 16'h0103,
                16'h0200, 16'h0203, 16'h0300, 16'h0301, 16'h0302, 16'h0303};
      issue(8'd0, 8'd0, 8'd4, 8'd4, 16'h07E0, 1'b1);
      total++;
      if (timed_out !== 1'b0 || wr_adr_q.size() !== 12) begin
         bad++; $display("FAIL outline_count: writes=%0d timeout=%b required 12/0", wr_adr_q.size(), timed_out);
      end
      for (int i = 0; i < wr_adr_q.size() && i < 12; i++) begin
         total++;
         if (wr_adr_q[i] !== exp_a[i] || wr_dat_q[i] !== 16'h07E0) begin
            bad++; $display("FAIL outline_write%0d: adr=%h data=%h required %h/07E0", i, wr_adr_q[i], wr_dat_q[i], exp_a[i]);
         end
      end
      interior = 0;
      foreach (wr_adr_q[i]) begin
         if (wr_adr_q[i] == 16'h0101 || wr_adr_q[i] == 16'h0102 ||
             wr_adr_q[i] == 16'h0201 || wr_adr_q[i] == 16'h0202) interior++;
      end
      total++;
      if (interior !== 0) begin
         bad++; $display("FAIL outline_interior: interior writes=%0d required 0", interior);
      end
      total++;
      if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 18 || ready_at !== 19) begin
         bad++; $display("FAIL outline_duration: ready_at=%0d required done at 18 (16 DRAW cycles), ready at 19", ready_at);
      end
   endtask

   task automatic test_clip();
      int over;
      issue(8'd238, 8'd239, 8'd10, 8'd5, 16'h1234, 1'b0);
      total++;
      if (wr_adr_q.size() !== 2) begin
         bad++; $display("FAIL clip_count: writes=%0d required 2", wr_adr_q.size());
      end else begin
         total++;
         if (wr_adr_q[0] !== 16'hEFEE || wr_adr_q[1] !== 16'hEFEF) begin
            bad++; $display("FAIL clip_addrs: got %h %h required EFEE EFEF", wr_adr_q[0], wr_adr_q[1]);
         end
      end
      over = 0;
      foreach (wr_adr_q[i]) if (wr_adr_q[i][7:0] > 8'd239 || wr_adr_q[i][15:8] > 8'd239) over++;
      total++;
      if (over !== 0 || ready_at !== 5) begin
         bad++; $display("FAIL clip_bounds: offscreen=%0d ready_at=%0d required 0/5", over, ready_at);
      end
   endtask

   task automatic test_reject();
      issue(8'd5, 8'd5, 8'd0, 8'd3, 16'hFFFF, 1'b0);
      total++;
      if (wr_adr_q.size() !== 0 || done_cyc_q.size() !== 1 || done_cyc_q[0] !== 2 || ready_at !== 3) begin
         bad++; $display("FAIL reject_w0: writes=%0d ready_at=%0d required 0 writes, done at 2, ready at 3",
                         wr_adr_q.size(), ready_at);
      end
      issue(8'd240, 8'd5, 8'd4, 8'd4, 16'hFFFF, 1'b0);
      total++;
      if (wr_adr_q.size() !== 0 || done_cyc_q.size() !== 1 || done_cyc_q[0] !== 2 || ready_at !== 3) begin
         bad++; $display("FAIL reject_x240: writes=%0d ready_at=%0d required 0 writes, done at 2, ready at 3",
                         wr_adr_q.size(), ready_at);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_a [5];
      int          exp_c [5];
      int          acc2_at;
      logic        acc2, fin;
      exp_a = '{16'h0505, 16'h0506, 16'h0605, 16'h0606, 16'h3C32};
      exp_c = '{2, 3, 4, 5, 9};
      wr_adr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
      w_cmd_x0 = 8'd5; w_cmd_y0 = 8'd5; w_cmd_w = 8'd2; w_cmd_h = 8'd2;
      w_cmd_color = 16'hAAAA; w_cmd_outline = 1'b0; w_cmd_valid = 1'b1;
      step();
      w_cmd_x0 = 8'd50; w_cmd_y0 = 8'd60; w_cmd_w = 8'd1; w_cmd_h = 8'd1;
      w_cmd_color = 16'h1234; w_cmd_outline = 1'b1;
      acc2 = 1'b0; fin = 1'b0; acc2_at = -1;
      for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
         if (w_st_we) begin
            wr_adr_q.push_back(w_st_wadr); wr_dat_q.push_back(w_st_wdata); wr_cyc_q.push_back(cyc);
         end
         if (w_done) done_cyc_q.push_back(cyc);
         if (w_cmd_ready) begin
            if (!acc2) begin acc2 = 1'b1; acc2_at = cyc; end
            else fin = 1'b1;
         end
         if (!fin) begin
            step();
            if (acc2) w_cmd_valid = 1'b0;
         end
      end
      w_cmd_valid = 1'b0;
      total++;
      if (acc2_at !== 7 || fin !== 1'b1) begin
         bad++; $display("FAIL b2b_accept: second accept cycle=%0d finished=%b required 7/1", acc2_at, fin);
      end
      total++;
      if (wr_adr_q.size() !== 5) begin
         bad++; $display("FAIL b2b_count: writes=%0d required 5", wr_adr_q.size());
      end
      for (int i = 0; i < wr_adr_q.size() && i < 5; i++) begin
         total++;
         if (wr_adr_q[i] !== exp_a[i] || wr_cyc_q[i] !== exp_c[i] ||
             wr_dat_q[i] !== ((i < 4) ? 16'hAAAA : 16'h1234)) begin
            bad++; $display("FAIL b2b_write%0d: adr=%h data=%h cycle=%0d required %h at %0d",
                            i, wr_adr_q[i], wr_dat_q[i], wr_cyc_q[i], exp_a[i], exp_c[i]);
         end
      end
      total++;
      if (done_cyc_q.size() !== 2 || done_cyc_q[0] !== 6 || done_cyc_q[1] !== 10) begin
         bad++; $display("FAIL b2b_done: pulses=%0d required at cycles 6 and 10", done_cyc_q.size());
      end
   endtask

   task automatic test_reset_mid_draw();
      int leaks;
      w_cmd_x0 = 8'd100; w_cmd_y0 = 8'd100; w_cmd_w = 8'd4; w_cmd_h = 8'd4;
      w_cmd_color = 16'h001F; w_cmd_outline = 1'b0; w_cmd_valid = 1'b1;
      step();
      w_cmd_valid = 1'b0;
      step(); step(); step();
      total++;
      if (w_st_we !== 1'b1 || w_st_wadr !== 16'h6466) begin
         bad++; $display("FAIL rst_draw_third: we=%b adr=%h required 1/6466", w_st_we, w_st_wadr);
      end
      #2 w_rst_n = 1'b0;
      #1;
      total++;
      if ({w_st_we, w_done, w_busy, w_cmd_ready} !== 4'b0000 || w_st_wadr !== 16'd0 || w_st_wdata !== 16'd0) begin
         bad++; $display("FAIL rst_async: we/done/busy/ready=%b adr=%h data=%h required all zero",
                         {w_st_we, w_done, w_busy, w_cmd_ready}, w_st_wadr, w_st_wdata);
      end
      leaks = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (w_st_we !== 1'b0 || w_done !== 1'b0) leaks++;
      end
      total++;
      if (leaks !== 0) begin
         bad++; $display("FAIL rst_hold: cycles with we/done during reset=%0d required 0", leaks);
      end
      #2 w_rst_n = 1'b1;
      #1;
      total++;
      if (w_cmd_ready !== 1'b0) begin
         bad++; $display("FAIL rst_release_early: ready=%b required 0", w_cmd_ready);
      end
      step();
      total++;
      if (w_cmd_ready !== 1'b1 || w_done !== 1'b0 || w_st_we !== 1'b0) begin
         bad++; $display("FAIL rst_release: ready=%b done=%b we=%b required 1/0/0", w_cmd_ready, w_done, w_st_we);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_outline();
      test_clip();
      test_reject();
      test_back_to_back();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
